multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Moore-style sequencing FSM for the multi-cycle RV32I datapath. Steps one instruction through FETCH, DECODE, EXECUTE, MEM and WRITEBACK, driving mux selects, write enables and the ALUOp class.
- Shares a single memory port between instruction fetch and load/store using a request/ready handshake.
- Traps on an illegal opcode or a memory timeout.

Parameters:
- TIMEOUT_CYCLES, default 255: maximum cycles a memory state waits for MemReady before trapping; 0 disables the timeout.
- TIMEOUT_W, default 8: width of the wait counter; must satisfy 2^TIMEOUT_W > TIMEOUT_CYCLES.

Ports:
- Clock  in  1  single system clock; all state updates on posedge.
- Reset  in  1  asynchronous, active-low reset.
- Instruction  in  7  opcode field from the IR; valid from DECODE onward.
- MemReady  in  1  memory completes the current read/write this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load qualified by ALU Zero (datapath ANDs).
- IRWrite  out  1  IR/OldPC load.
- IorD  out  1  memory address: 0=PC, 1=ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- MemToReg  out  2  writeback source: 00=ALUOut, 01=MDR, 10=PC (PC+4).
- RegWrite  out  1  register file write enable.
- ALUSrcA  out  2  00=PC, 01=rs1, 10=OldPC.
- ALUSrcB  out  2  00=rs2, 01=constant 4, 10=imm.
- ALUOp  out  2  00=add, 01=branch compare, 10=R funct, 11=I funct.
- PCSource  out  2  00=ALU result, 01=ALUOut.
- Retired  out  1  one-cycle pulse on the last cycle of each completed instruction.
- Trap  out  1  sticky; FSM halted.
- Cause  out  2  00=none, 01=illegal opcode, 10=memory timeout.

Behaviour:
- Reset low (async): state=FETCH, wait counter=0, latched opcode=0, Cause=00. While Reset is low, every output is forced to 0.
- After Reset releases, outputs decode from the current state. Any output not listed for a state is 0.
- FETCH: MemRead=1, IorD=0, ALUSrcA=00, ALUSrcB=01, ALUOp=00.
  - On MemReady: IRWrite=1, PCWrite=1, PCSource=00, next state DECODE.
  - Otherwise stay in FETCH.
- DECODE: ALUSrcA=10, ALUSrcB=10, ALUOp=00 (branch target into ALUOut). Latch Instruction into the internal opcode register. Next state by opcode:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 or 0100011 -> MEM_ADDR
  - 1100011 -> BRANCH
  - 1101111 or 1100111 -> JUMP
  - any other -> TRAP with Cause=01
- EXEC_R: ALUSrcA=01, ALUSrcB=00, ALUOp=10; next WB_ALU.
- EXEC_I: ALUSrcA=01, ALUSrcB=10, ALUOp=11; next WB_ALU.
- MEM_ADDR: ALUSrcA=01, ALUSrcB=10, ALUOp=00. Next MEM_RD if latched opcode is 0000011, else MEM_WR.
- MEM_RD: MemRead=1, IorD=1; on MemReady next WB_MEM.
- MEM_WR: MemWrite=1, IorD=1; on MemReady Retired=1, next FETCH.
- WB_ALU: RegWrite=1, MemToReg=00, Retired=1; next FETCH.
- WB_MEM: RegWrite=1, MemToReg=01, Retired=1; next FETCH.
- BRANCH: ALUSrcA=01, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, Retired=1; next FETCH.
- JUMP: RegWrite=1, MemToReg=10 (PC already holds PC+4), PCWrite=1, PCSource=00, ALUSrcB=10, ALUOp=00, Retired=1; next FETCH.
  - JAL (1101111): ALUSrcA=10.
  - JALR (1100111): ALUSrcA=01. The datapath clears bit 0 of the target.
- Register-file write and PC load happen on the same edge. The register file uses the pre-edge PC value.
- Wait counter (FETCH/MEM_RD/MEM_WR):
  - Cleared on entry to any of these states and whenever MemReady=1; increments each cycle MemReady=0.
  - If TIMEOUT_CYCLES≠0 and the counter equals TIMEOUT_CYCLES with MemReady=0, next state is TRAP with Cause=10.
  - MemReady arriving in that same cycle wins: no trap.
- TRAP: Trap=1, Cause held, all other outputs 0. Exits only on reset.
- Latency (MemReady tied high), counting from FETCH entry to the Retired pulse:
  - R/I: 4 cycles
  - load: 5 cycles
  - store: 4 cycles
  - branch/jump: 3 cycles
- Reset asserted mid-instruction: outputs drop to 0 immediately (async) and the FSM restarts at FETCH. No partial writeback.

Test Plan:
- Reset low for 3 cycles, then high, MemReady=1, Instruction=0110011 -> all outputs 0 during reset; then FETCH/DECODE/EXEC_R/WB_ALU; RegWrite=1 and Retired=1 on cycle 4; FETCH resumes on cycle 5.
- Load 0000011 with MemReady held low 2 cycles in MEM_RD -> MemRead=1 and IorD=1 held 3 cycles; WB_MEM has MemToReg=01; Retired on cycle 7.
- Store 0100011 followed by branch 1100011 -> MEM_WR has MemWrite=1 with RegWrite=0; BRANCH has PCWriteCond=1, PCSource=01, ALUOp=01.
- JAL 1101111 then JALR 1100111 -> JUMP has MemToReg=10, PCWrite=1, and ALUSrcA=10 (JAL) then 01 (JALR).
- Instruction=1111111 -> TRAP after DECODE: Trap=1, Cause=01, MemRead=0 indefinitely; Reset low clears Trap and Cause.
- TIMEOUT_CYCLES=4, MemReady=0 in FETCH -> Trap=1, Cause=10 after 5 FETCH cycles; with MemReady=1 on that 5th cycle instead -> no trap, DECODE.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I sequencing FSM (Moore outputs, two exceptions: FETCH and
// MEM_WR also qualify some strobes with MemReady). One memory port is shared
// between instruction fetch and load/store through a MemRead/MemWrite +
// MemReady handshake. Illegal opcodes and memory timeouts halt in TRAP.
module multicycle_control #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_W      = 8
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [6:0] Instruction,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IRWrite,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic [1:0] MemToReg,
    output logic       RegWrite,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       Retired,
    output logic       Trap,
    output logic [1:0] Cause
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    localparam logic [TIMEOUT_W-1:0] TIMEOUT_VAL = TIMEOUT_W'(TIMEOUT_CYCLES);

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WR,
        S_WB_ALU,
        S_WB_MEM,
        S_BRANCH,
        S_JUMP,
        S_TRAP
    } state_t;

    state_t               state, state_nxt;
    logic [TIMEOUT_W-1:0] wait_cnt;
    logic [6:0]           opcode;
    logic [1:0]           cause_q, cause_nxt;
    logic                 mem_state;
    logic                 timeout_hit;

    // States that hold the shared memory port and therefore can time out.
    assign mem_state   = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
    // A MemReady arriving on the limit cycle wins over the timeout.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && mem_state &&
                         (wait_cnt == TIMEOUT_VAL) && !MemReady;

    // State, cause and latched opcode registers.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state   <= S_FETCH;
            cause_q <= CAUSE_NONE;
            opcode  <= 7'd0;
        end else begin
            state   <= state_nxt;
            cause_q <= cause_nxt;
            if (state == S_DECODE)
                opcode <= Instruction;
        end
    end

    // Wait counter: restarts on every state change and on each handshake,
    // counts stalled cycles while a memory request is outstanding.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset)
            wait_cnt <= '0;
        else if (state_nxt != state || MemReady)
            wait_cnt <= '0;
        else if (mem_state)
            wait_cnt <= wait_cnt + TIMEOUT_W'(1);
    end

    // Next-state and trap cause selection.
    always_comb begin
        state_nxt = state;
        cause_nxt = cause_q;
        case (state)
            S_FETCH: begin
                if (MemReady)         state_nxt = S_DECODE;
                else if (timeout_hit) begin
                    state_nxt = S_TRAP;
                    cause_nxt = CAUSE_TIMEOUT;
                end
            end
            S_DECODE: begin
                case (Instruction)
                    OP_R:               state_nxt = S_EXEC_R;
                    OP_I:               state_nxt = S_EXEC_I;
                    OP_LOAD, OP_STORE:  state_nxt = S_MEM_ADDR;
                    OP_BRANCH:          state_nxt = S_BRANCH;
                    OP_JAL, OP_JALR:    state_nxt = S_JUMP;
                    default: begin
                        state_nxt = S_TRAP;
                        cause_nxt = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_EXEC_R, S_EXEC_I: state_nxt = S_WB_ALU;
            S_MEM_ADDR: state_nxt = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD, S_MEM_WR: begin
                if (MemReady)
                    state_nxt = (state == S_MEM_RD) ? S_WB_MEM : S_FETCH;
                else if (timeout_hit) begin
                    state_nxt = S_TRAP;
                    cause_nxt = CAUSE_TIMEOUT;
                end
            end
            S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP: state_nxt = S_FETCH;
            S_TRAP:   state_nxt = S_TRAP;
            default:  state_nxt = S_FETCH;
        endcase
    end

    // Control outputs decoded from state; all forced low while in reset.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IRWrite     = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemToReg    = 2'b00;
        RegWrite    = 1'b0;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        Retired     = 1'b0;
        Trap        = 1'b0;
        Cause       = 2'b00;
        if (Reset) begin
            case (state)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    if (MemReady) begin
                        IRWrite = 1'b1;
                        PCWrite = 1'b1;
                    end
                end
                S_DECODE: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b10;
                end
                S_EXEC_R: begin
                    ALUSrcA = 2'b01;
                    ALUOp   = 2'b10;
                end
                S_EXEC_I: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b10;
                    ALUOp   = 2'b11;
                end
                S_MEM_ADDR: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b10;
                end
                S_MEM_RD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEM_WR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                    Retired  = MemReady;
                end
                S_WB_ALU: begin
                    RegWrite = 1'b1;
                    Retired  = 1'b1;
                end
                S_WB_MEM: begin
                    RegWrite = 1'b1;
                    MemToReg = 2'b01;
                    Retired  = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA     = 2'b01;
                    ALUOp       = 2'b01;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                    Retired     = 1'b1;
                end
                S_JUMP: begin
                    // Link value is the already-incremented PC.
                    RegWrite = 1'b1;
                    MemToReg = 2'b10;
                    PCWrite  = 1'b1;
                    ALUSrcB  = 2'b10;
                    ALUSrcA  = (opcode == OP_JALR) ? 2'b01 : 2'b10;
                    Retired  = 1'b1;
                end
                S_TRAP: begin
                    Trap  = 1'b1;
                    Cause = cause_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed per-cycle vector table for the
// corner cases, then randomized opcodes/MemReady/reset checked against a
// step-queue reference model.
module tb_multicycle_control;

    localparam int TO = 4;

    localparam logic [6:0] R   = 7'b0110011;
    localparam logic [6:0] OPI = 7'b0010011;
    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] ST  = 7'b0100011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] JAL = 7'b1101111;
    localparam logic [6:0] JLR = 7'b1100111;
    localparam logic [6:0] BAD = 7'b1111111;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic [6:0] Instruction = 7'd0;
    logic       MemReady = 1'b0;
    logic       PCWrite, PCWriteCond, IRWrite, IorD, MemRead, MemWrite, RegWrite;
    logic       Retired, Trap;
    logic [1:0] MemToReg, ALUSrcA, ALUSrcB, ALUOp, PCSource, Cause;

    multicycle_control #(.TIMEOUT_CYCLES(TO), .TIMEOUT_W(3)) dut (
        .Clock(Clock), .Reset(Reset), .Instruction(Instruction), .MemReady(MemReady),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IRWrite(IRWrite), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
        .Retired(Retired), .Trap(Trap), .Cause(Cause)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic       pcw, pcwc, irw, iord, mr, mw;
        logic [1:0] m2r;
        logic       rw;
        logic [1:0] asa, asb, op, pcs;
        logic       ret, trap;
        logic [1:0] cause;
    } outs_t;

    typedef struct {
        logic       rst;
        logic [6:0] ins;
        logic       rdy;
        outs_t      exp;
    } vec_t;

    typedef struct {
        outs_t base;
        outs_t rdy_extra;
        bit    mem;
        bit    dec;
    } step_t;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic outs_t ov(input logic pcw, pcwc, irw, iord, mr, mw,
                                 input logic [1:0] m2r, input logic rw,
                                 input logic [1:0] asa, asb, op, pcs,
                                 input logic ret, trap, input logic [1:0] cause);
        outs_t o;
        o.pcw = pcw; o.pcwc = pcwc; o.irw = irw; o.iord = iord; o.mr = mr; o.mw = mw;
        o.m2r = m2r; o.rw = rw; o.asa = asa; o.asb = asb; o.op = op; o.pcs = pcs;
        o.ret = ret; o.trap = trap; o.cause = cause;
        return o;
    endfunction

    //                        pcw pcwc irw iord mr mw m2r rw asa asb op pcs ret trap cause
    function automatic outs_t o_fetch();  return ov(0,0,0,0,1,0, 0,0, 0,1,0,0, 0,0,0); endfunction
    function automatic outs_t o_fetchr(); return ov(1,0,1,0,1,0, 0,0, 0,1,0,0, 0,0,0); endfunction
    function automatic outs_t o_dec();    return ov(0,0,0,0,0,0, 0,0, 2,2,0,0, 0,0,0); endfunction
    function automatic outs_t o_exr();    return ov(0,0,0,0,0,0, 0,0, 1,0,2,0, 0,0,0); endfunction
    function automatic outs_t o_exi();    return ov(0,0,0,0,0,0, 0,0, 1,2,3,0, 0,0,0); endfunction
    function automatic outs_t o_addr();   return ov(0,0,0,0,0,0, 0,0, 1,2,0,0, 0,0,0); endfunction
    function automatic outs_t o_rd();     return ov(0,0,0,1,1,0, 0,0, 0,0,0,0, 0,0,0); endfunction
    function automatic outs_t o_wr();     return ov(0,0,0,1,0,1, 0,0, 0,0,0,0, 0,0,0); endfunction
    function automatic outs_t o_wrr();    return ov(0,0,0,1,0,1, 0,0, 0,0,0,0, 1,0,0); endfunction
    function automatic outs_t o_wba();    return ov(0,0,0,0,0,0, 0,1, 0,0,0,0, 1,0,0); endfunction
    function automatic outs_t o_wbm();    return ov(0,0,0,0,0,0, 1,1, 0,0,0,0, 1,0,0); endfunction
    function automatic outs_t o_br();     return ov(0,1,0,0,0,0, 0,0, 1,0,1,1, 1,0,0); endfunction
    function automatic outs_t o_jal();    return ov(1,0,0,0,0,0, 2,1, 2,2,0,0, 1,0,0); endfunction
    function automatic outs_t o_jalr();   return ov(1,0,0,0,0,0, 2,1, 1,2,0,0, 1,0,0); endfunction
    function automatic outs_t o_trap(input logic [1:0] c);
        return ov(0,0,0,0,0,0, 0,0, 0,0,0,0, 0,1,c);
    endfunction

    function automatic outs_t sample();
        outs_t s;
        s.pcw = PCWrite; s.pcwc = PCWriteCond; s.irw = IRWrite; s.iord = IorD;
        s.mr = MemRead; s.mw = MemWrite; s.m2r = MemToReg; s.rw = RegWrite;
        s.asa = ALUSrcA; s.asb = ALUSrcB; s.op = ALUOp; s.pcs = PCSource;
        s.ret = Retired; s.trap = Trap; s.cause = Cause;
        return s;
    endfunction

    task automatic chk(input string nm, input outs_t got, input outs_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // ---------------- reference model: queue of remaining steps ----------------
    step_t      q[$];
    bit         m_trap;
    logic [1:0] m_cause;
    int         m_wait;

    function automatic step_t mk(input outs_t b, input outs_t x, input bit mem, input bit dec);
        step_t s;
        s.base = b; s.rdy_extra = x; s.mem = mem; s.dec = dec;
        return s;
    endfunction

    task automatic m_reset();
        q.delete();
        q.push_back(mk(o_fetch(), o_fetchr(), 1, 0));
        q.push_back(mk(o_dec(), '0, 0, 1));
        m_trap = 0; m_cause = 2'b00; m_wait = 0;
    endtask

    function automatic outs_t m_expect();
        outs_t e;
        if (!Reset) return '0;
        if (m_trap) return o_trap(m_cause);
        e = q[0].base;
        if (q[0].mem && MemReady) e = outs_t'(e | q[0].rdy_extra);
        return e;
    endfunction

    task automatic m_update();
        step_t h;
        if (!Reset) begin
            m_reset();
            return;
        end
        if (m_trap) return;
        h = q[0];
        if (h.mem && !MemReady) begin
            if (m_wait == TO) begin m_trap = 1; m_cause = 2'b10; end
            else m_wait++;
            return;
        end
        void'(q.pop_front());
        m_wait = 0;
        if (h.dec) begin
            case (Instruction)
                R:   begin q.push_back(mk(o_exr(), '0, 0, 0)); q.push_back(mk(o_wba(), '0, 0, 0)); end
                OPI: begin q.push_back(mk(o_exi(), '0, 0, 0)); q.push_back(mk(o_wba(), '0, 0, 0)); end
                LD:  begin q.push_back(mk(o_addr(), '0, 0, 0)); q.push_back(mk(o_rd(), '0, 1, 0));
                           q.push_back(mk(o_wbm(), '0, 0, 0)); end
                ST:  begin q.push_back(mk(o_addr(), '0, 0, 0)); q.push_back(mk(o_wr(), o_wrr(), 1, 0)); end
                BR:  q.push_back(mk(o_br(), '0, 0, 0));
                JAL: q.push_back(mk(o_jal(), '0, 0, 0));
                JLR: q.push_back(mk(o_jalr(), '0, 0, 0));
                default: begin m_trap = 1; m_cause = 2'b01; end
            endcase
        end
        if (q.size() == 0) begin
            q.push_back(mk(o_fetch(), o_fetchr(), 1, 0));
            q.push_back(mk(o_dec(), '0, 0, 1));
        end
    endtask

    // One clock: drive inputs, sample at negedge, then let DUT and model step.
    task automatic cycle(input logic r, input logic [6:0] ins, input logic rdy, output outs_t got);
        Reset = r; Instruction = ins; MemReady = rdy;
        @(negedge Clock);
        got = sample();
        @(posedge Clock);
        m_update();
        #1;
    endtask

    vec_t tbl[$];

    task automatic v(input logic r, input logic [6:0] i, input logic m, input outs_t e);
        vec_t x;
        x.rst = r; x.ins = i; x.rdy = m; x.exp = e;
        tbl.push_back(x);
    endtask

    initial begin
        outs_t got, exp;
        int trap_run;
        int stall_pct;
        logic r, rdy;
        logic [6:0] ins;
        logic [6:0] legal [7];

        legal[0] = R; legal[1] = OPI; legal[2] = LD; legal[3] = ST;
        legal[4] = BR; legal[5] = JAL; legal[6] = JLR;
        m_reset();

        // reset then R-type, MemReady held high
        repeat (3) v(0, R, 1, '0);
        v(1, R, 1, o_fetchr()); v(1, R, 1, o_dec()); v(1, R, 1, o_exr()); v(1, R, 1, o_wba());
        // load with two stall cycles; opcode input changes after DECODE
        v(1, R, 1, o_fetchr()); v(1, LD, 1, o_dec()); v(1, 7'd0, 1, o_addr());
        v(1, 7'd0, 0, o_rd()); v(1, 7'd0, 0, o_rd()); v(1, 7'd0, 1, o_rd()); v(1, 7'd0, 1, o_wbm());
        // store with one stall, then branch
        v(1, 7'd0, 1, o_fetchr()); v(1, ST, 1, o_dec()); v(1, LD, 1, o_addr());
        v(1, LD, 0, o_wr()); v(1, LD, 1, o_wrr());
        v(1, R, 1, o_fetchr()); v(1, BR, 1, o_dec()); v(1, R, 1, o_br());
        // JAL then JALR, with the opposite opcode presented during JUMP
        v(1, R, 1, o_fetchr()); v(1, JAL, 1, o_dec()); v(1, JLR, 1, o_jal());
        v(1, R, 1, o_fetchr()); v(1, JLR, 1, o_dec()); v(1, JAL, 1, o_jalr());
        // I-type
        v(1, R, 1, o_fetchr()); v(1, OPI, 1, o_dec()); v(1, OPI, 1, o_exi()); v(1, R, 1, o_wba());
        // illegal opcode traps and stays; reset clears
        v(1, R, 1, o_fetchr()); v(1, BAD, 1, o_dec());
        repeat (3) v(1, R, 1, o_trap(2'b01));
        v(0, R, 1, '0);
        v(1, R, 1, o_fetchr()); v(1, R, 1, o_dec()); v(1, R, 1, o_exr()); v(1, R, 1, o_wba());
        // fetch timeout after five stalled cycles
        repeat (5) v(1, R, 0, o_fetch());
        repeat (2) v(1, R, 1, o_trap(2'b10));
        v(0, R, 0, '0);
        // ready on the limit cycle wins
        repeat (4) v(1, R, 0, o_fetch());
        v(1, R, 1, o_fetchr()); v(1, R, 1, o_dec()); v(1, R, 1, o_exr()); v(1, R, 1, o_wba());
        // load timeout in MEM_RD
        v(1, R, 1, o_fetchr()); v(1, LD, 1, o_dec()); v(1, LD, 1, o_addr());
        repeat (5) v(1, LD, 0, o_rd());
        v(1, LD, 1, o_trap(2'b10));
        v(0, R, 1, '0);

        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i].rst, tbl[i].ins, tbl[i].rdy, got);
            chk($sformatf("vec%0d", i), got, tbl[i].exp);
        end

        // async reset in the middle of WB_ALU: outputs must drop at once
        cycle(1, R, 1, got); chk("mid_fetch", got, o_fetchr());
        cycle(1, R, 1, got); chk("mid_dec", got, o_dec());
        cycle(1, R, 1, got); chk("mid_exr", got, o_exr());
        Reset = 1; @(negedge Clock); chk("mid_wba", sample(), o_wba());
        Reset = 0; #1; chk("mid_async_rst", sample(), '0);
        @(posedge Clock); m_update(); #1;
        cycle(1, R, 0, got); chk("mid_restart", got, o_fetch());

        // randomized run against the step-queue model
        cycle(0, R, 1, got); chk("rnd_rst", got, '0);
        trap_run = 0;
        stall_pct = 30;
        for (int c = 0; c < 4000; c++) begin
            if (c % 64 == 0) stall_pct = ($urandom_range(3) == 0) ? 85 : 25;
            r   = (trap_run > 3 || $urandom_range(99) < 2) ? 1'b0 : 1'b1;
            ins = ($urandom_range(99) < 90) ? legal[$urandom_range(6)] : 7'($urandom);
            rdy = ($urandom_range(99) >= stall_pct);
            Reset = r; Instruction = ins; MemReady = rdy;
            @(negedge Clock);
            exp = m_expect();
            chk($sformatf("rnd%0d", c), sample(), exp);
            @(posedge Clock);
            m_update();
            #1;
            trap_run = m_trap ? trap_run + 1 : 0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
